// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   - data/register-address widths, zero word, write-disable level
//   - memory operation codes (ex_memop encoding)
//   - stage FSM state encoding
//   - helpers classifying a memop as load/store/misaligned
// Optional feature macro used by the stage: MEM_ALIGN_CHK_EN.
package mem_stage_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned MEMOP_W    = 4;

    localparam logic [WORD_W-1:0] ZERO_WORD     = '0;
    localparam logic              WRITE_DISABLE = 1'b0;

    typedef enum logic [MEMOP_W-1:0] {
        MEMOP_NONE = 4'd0,
        MEMOP_LB   = 4'd1,
        MEMOP_LBU  = 4'd2,
        MEMOP_LH   = 4'd3,
        MEMOP_LHU  = 4'd4,
        MEMOP_LW   = 4'd5,
        MEMOP_SB   = 4'd8,
        MEMOP_SH   = 4'd9,
        MEMOP_SW   = 4'd10
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    function automatic logic memop_is_load(input logic [MEMOP_W-1:0] op);
        return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
               (op == MEMOP_LHU) || (op == MEMOP_LW);
    endfunction

    function automatic logic memop_is_store(input logic [MEMOP_W-1:0] op);
        return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
    function automatic logic memop_misaligned(input logic [MEMOP_W-1:0] op,
                                              input logic [1:0]         addr_lo);
        logic half_op;
        logic word_op;
        half_op = (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
        word_op = (op == MEMOP_LW) || (op == MEMOP_SW);
        return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: req/ack data bus between the MEM stage and data memory.
//   req    master->slave  request, held until ack
//   we     master->slave  1 = store
//   addr   master->slave  word-aligned address
//   sel    master->slave  byte-lane enables
//   wdata  master->slave  store data replicated to lanes
//   rdata  slave->master  load data, valid with ack
//   ack    slave->master  transfer complete
interface mem_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [3:0]        sel;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, we, addr, sel, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational byte-lane handling for the MEM stage.
//   memop      in   operation code
//   addr_lo    in   effective address bits [1:0]
//   sdata      in   store data (low bytes used for SB/SH)
//   rdata      in   captured load word
//   load_data  out  lane-selected, sign/zero-extended load result
//   sel        out  byte-lane enables for stores
//   wdata      out  store data replicated across lanes
// Misaligned halfword/word accesses fall back to lane pair 0 / the full word.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [MEMOP_W-1:0] memop,
    input  logic [1:0]         addr_lo,
    input  logic [WORD_W-1:0]  sdata,
    input  logic [WORD_W-1:0]  rdata,
    output logic [WORD_W-1:0]  load_data,
    output logic [3:0]         sel,
    output logic [WORD_W-1:0]  wdata
);

    logic [WORD_W-1:0] byte_shifted;
    logic [7:0]        ld_byte;
    logic              half_hi;
    logic [15:0]       ld_half;

    assign byte_shifted = rdata >> {addr_lo, 3'b000};
    assign ld_byte      = byte_shifted[7:0];
    // Odd halfword addresses are treated as lane pair 0.
    assign half_hi      = addr_lo[1] & ~addr_lo[0];
    assign ld_half      = half_hi ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = rdata;
        case (memop)
            MEMOP_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
            MEMOP_LBU: load_data = {24'h000000, ld_byte};
            MEMOP_LH:  load_data = {{16{ld_half[15]}}, ld_half};
            MEMOP_LHU: load_data = {16'h0000, ld_half};
            default:   load_data = rdata;
        endcase
    end

    always_comb begin
        sel   = 4'b0000;
        wdata = sdata;
        case (memop)
            MEMOP_SB: begin
                sel   = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            MEMOP_SH: begin
                sel   = half_hi ? 4'b1100 : 4'b0011;
                wdata = {2{sdata[15:0]}};
            end
            MEMOP_SW: begin
                sel   = 4'b1111;
                wdata = sdata;
            end
            default: begin
                sel   = 4'b0000;
                wdata = sdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between the EX/MEM register and mem_wb.
// Non-memory ops pass the ALU result through combinationally; loads and
// stores raise a bus request and stall the pipeline until the bus acks.
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   ex_wdata/ex_wd/ex_reg    ALU result, destination register, write enable
//   ex_memop/ex_maddr/ex_sdata  memory op code, effective address, store data
//   flush                    discard current instruction
//   dbus (master)            req/ack data bus
//   mem_wdata/mem_wd/mem_reg write-back info to mem_wb
//   stallreq                 pipeline stall request
//   mem_excp_align           misalignment exception (MEM_ALIGN_CHK_EN only)
// Optional feature macro: MEM_ALIGN_CHK_EN (misaligned ops trap instead of
// being issued with lane 0 / lane pair 0).
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  ex_wdata,
    input  logic [RADDR_W-1:0] ex_wd,
    input  logic               ex_reg,
    input  logic [3:0]         ex_memop,
    input  logic [DATA_W-1:0]  ex_maddr,
    input  logic [DATA_W-1:0]  ex_sdata,
    input  logic               flush,
    mem_stage_if.master        dbus,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [RADDR_W-1:0] mem_wd,
    output logic               mem_reg,
    output logic               stallreq
`ifdef MEM_ALIGN_CHK_EN
    ,
    output logic               mem_excp_align
`endif
);

    state_e            state_q, state_nx;
    logic [DATA_W-1:0] rdata_q;
    logic              flushed_q, flushed_nx;
    logic              acked_q, acked_nx;
    logic              capture;

    logic              op_load, op_store, op_valid, align_err;
    logic [DATA_W-1:0] load_fmt;
    logic [3:0]        st_sel;
    logic [DATA_W-1:0] st_wdata;
    logic              req_c;

    assign op_load  = memop_is_load(ex_memop);
    assign op_store = memop_is_store(ex_memop);
    assign op_valid = op_load | op_store;

`ifdef MEM_ALIGN_CHK_EN
    assign align_err      = memop_misaligned(ex_memop, ex_maddr[1:0]);
    assign mem_excp_align = rst && (state_q == ST_IDLE) && op_valid && !flush && align_err;
`else
    assign align_err = 1'b0;
`endif

    lsu_align u_lsu_align (
        .memop     (ex_memop),
        .addr_lo   (ex_maddr[1:0]),
        .sdata     (ex_sdata),
        .rdata     (rdata_q),
        .load_data (load_fmt),
        .sel       (st_sel),
        .wdata     (st_wdata)
    );

    // Upstream is held by the stall, so bus fields come straight from ex_*.
    assign dbus.req   = req_c;
    assign dbus.we    = op_store;
    assign dbus.addr  = {ex_maddr[DATA_W-1:2], 2'b00};
    assign dbus.sel   = st_sel;
    assign dbus.wdata = st_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rdata_q   <= ZERO_WORD;
            flushed_q <= 1'b0;
            acked_q   <= 1'b0;
        end else begin
            state_q   <= state_nx;
            flushed_q <= flushed_nx;
            acked_q   <= acked_nx;
            if (capture) begin
                rdata_q <= dbus.rdata;
            end
        end
    end

    always_comb begin
        state_nx   = state_q;
        flushed_nx = flushed_q;
        acked_nx   = acked_q;
        capture    = 1'b0;
        req_c      = 1'b0;
        stallreq   = 1'b0;
        mem_wdata  = ex_wdata;
        mem_wd     = ex_wd;
        mem_reg    = WRITE_DISABLE;

        case (state_q)
            ST_IDLE: begin
                if (op_valid && !flush && !align_err) begin
                    req_c      = 1'b1;
                    stallreq   = 1'b1;
                    flushed_nx = 1'b0;
                    state_nx   = ST_WAIT;
                    // An ack in the request cycle completes the transfer;
                    // WAIT then only finishes the minimum stall without
                    // re-requesting.
                    if (dbus.ack) begin
                        capture  = 1'b1;
                        acked_nx = 1'b1;
                    end
                end else begin
                    mem_reg = ex_reg & ~flush & ~op_valid;
                end
            end
            ST_WAIT: begin
                stallreq = 1'b1;
                req_c    = ~acked_q;
                if (flush) begin
                    flushed_nx = 1'b1;
                end
                if (acked_q) begin
                    acked_nx = 1'b0;
                    state_nx = ST_DONE;
                end else if (dbus.ack) begin
                    capture  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                mem_reg    = ex_reg & op_load & ~flushed_q & ~flush;
                mem_wdata  = op_load ? load_fmt : ex_wdata;
                flushed_nx = 1'b0;
                state_nx   = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        if (!rst) begin
            req_c     = 1'b0;
            stallreq  = 1'b0;
            mem_reg   = WRITE_DISABLE;
            mem_wdata = ZERO_WORD;
            mem_wd    = '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_wdata, ex_maddr, ex_sdata;
    logic [4:0]  ex_wd;
    logic        ex_reg, flush;
    logic [3:0]  ex_memop;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_wd;
    logic        mem_reg, stallreq;
`ifdef MEM_ALIGN_CHK_EN
    logic        mem_excp_align;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_if #(.DATA_W(32)) dbus ();

    mem_stage #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .ex_wdata  (ex_wdata),
        .ex_wd     (ex_wd),
        .ex_reg    (ex_reg),
        .ex_memop  (ex_memop),
        .ex_maddr  (ex_maddr),
        .ex_sdata  (ex_sdata),
        .flush     (flush),
        .dbus      (dbus),
        .mem_wdata (mem_wdata),
        .mem_wd    (mem_wd),
        .mem_reg   (mem_reg),
        .stallreq  (stallreq)
`ifdef MEM_ALIGN_CHK_EN
        ,
        .mem_excp_align (mem_excp_align)
`endif
    );

    // ---------------- reference model ----------------
    function automatic bit ref_is_load(input int op);
        return (op >= 1) && (op <= 5);
    endfunction

    function automatic bit ref_is_store(input int op);
        return (op == 8) || (op == 9) || (op == 10);
    endfunction

    function automatic bit ref_misaligned(input int op, input logic [31:0] addr);
        int a;
        a = int'(addr % 4);
        if (op == 3 || op == 4 || op == 9) return (a % 2) != 0;
        if (op == 5 || op == 10) return a != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        longint v;
        int     lane;
        v = longint'(rd);
        if (op == 1 || op == 2) begin
            lane = int'(addr % 4);
            v = longint'((rd >> (8 * lane)) & 32'hFF);
            if (op == 1 && v >= 128) v = v - 256;
        end else if (op == 3 || op == 4) begin
            lane = ((addr % 2) != 0) ? 0 : int'((addr % 4) / 2);
            v = longint'((rd >> (16 * lane)) & 32'hFFFF);
            if (op == 3 && v >= 32768) v = v - 65536;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] ref_sel(input int op, input logic [31:0] addr);
        int s;
        s = 0;
        if (op == 8) s = 1 << (addr % 4);
        else if (op == 9) s = ((addr % 2) != 0) ? 3 : (3 << (2 * ((addr % 4) / 2)));
        else if (op == 10) s = 15;
        return s[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] sd);
        if (op == 8) return (sd & 32'hFF) * 32'h01010101;
        if (op == 9) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    // ---------------- memory transaction driver + checks ----------------
    task automatic run_mem(input int op, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [31:0] alu, input logic [4:0] wd, input bit reg_en,
                           input int ack_at, input logic [31:0] rdata,
                           input int flush_at, input bit flush_done, input string tag);
        int          stall_cycles;
        bit          flushed;
        logic [31:0] exp_wdata;
        bit          exp_reg;
        stall_cycles = (ack_at < 1) ? 2 : ack_at + 1;
        flushed      = 1'b0;
        ex_memop = op[3:0]; ex_maddr = addr; ex_sdata = sd;
        ex_wdata = alu; ex_wd = wd; ex_reg = reg_en; flush = 1'b0;
        for (int c = 0; c < stall_cycles; c++) begin
            flush = (c == flush_at);
            if (c == flush_at) flushed = 1'b1;
            #1;
            n_cmp++;
            if (stallreq !== 1'b1) begin
                n_err++; $display("FAIL %s stall c%0d: got %b want 1", tag, c, stallreq);
            end
            if (!(ack_at == 0 && c >= 1)) begin
                n_cmp++;
                if (dbus.req !== 1'b1) begin
                    n_err++; $display("FAIL %s req c%0d: got %b want 1", tag, c, dbus.req);
                end
            end
            n_cmp++;
            if (mem_reg !== 1'b0) begin
                n_err++; $display("FAIL %s mem_reg stalled c%0d: got %b want 0", tag, c, mem_reg);
            end
            if (c == 0) begin
                n_cmp++;
                if (dbus.addr !== {addr[31:2], 2'b00} || dbus.we !== ref_is_store(op)) begin
                    n_err++;
                    $display("FAIL %s addr/we: got %h/%b want %h/%b", tag, dbus.addr, dbus.we,
                             {addr[31:2], 2'b00}, ref_is_store(op));
                end
                if (ref_is_store(op)) begin
                    n_cmp++;
                    if (dbus.sel !== ref_sel(op, addr) || dbus.wdata !== ref_wdata(op, sd)) begin
                        n_err++;
                        $display("FAIL %s sel/wdata: got %b/%h want %b/%h", tag, dbus.sel,
                                 dbus.wdata, ref_sel(op, addr), ref_wdata(op, sd));
                    end
                end
`ifdef MEM_ALIGN_CHK_EN
                n_cmp++;
                if (mem_excp_align !== 1'b0) begin
                    n_err++; $display("FAIL %s excp aligned: got %b want 0", tag, mem_excp_align);
                end
`endif
            end
            dbus.ack   = (c == ack_at);
            dbus.rdata = (c == ack_at) ? rdata : $urandom;
            @(posedge clk);
            #1;
            dbus.ack = 1'b0;
            flush    = 1'b0;
            @(negedge clk);
        end
        // completion cycle
        flush = flush_done;
        #1;
        exp_wdata = ref_is_load(op) ? ref_load(op, addr, rdata) : alu;
        exp_reg   = reg_en && ref_is_load(op) && !flushed && !flush_done;
        n_cmp++;
        if (stallreq !== 1'b0 || dbus.req !== 1'b0) begin
            n_err++; $display("FAIL %s done stall/req: got %b/%b want 0/0", tag, stallreq, dbus.req);
        end
        n_cmp++;
        if (mem_wdata !== exp_wdata) begin
            n_err++; $display("FAIL %s done wdata: got %h want %h", tag, mem_wdata, exp_wdata);
        end
        n_cmp++;
        if (mem_reg !== exp_reg || mem_wd !== wd) begin
            n_err++;
            $display("FAIL %s done reg/wd: got %b/%0d want %b/%0d", tag, mem_reg, mem_wd, exp_reg, wd);
        end
        @(posedge clk);
        #1;
        flush = 1'b0; ex_memop = 4'd0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; ex_memop = 4'd5; ex_wdata = $urandom; ex_wd = 5'd9; ex_reg = 1'b1;
        ex_maddr = 32'h100; ex_sdata = $urandom; flush = 1'b0;
        dbus.ack = 1'b0; dbus.rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (dbus.req !== 1'b0 || stallreq !== 1'b0 || mem_reg !== 1'b0) begin
            n_err++; $display("FAIL reset ctl: req=%b stall=%b reg=%b want 0", dbus.req, stallreq, mem_reg);
        end
        n_cmp++;
        if (mem_wdata !== 32'h0 || mem_wd !== 5'd0) begin
            n_err++; $display("FAIL reset data: wdata=%h wd=%0d want 0", mem_wdata, mem_wd);
        end
        ex_memop = 4'd0; rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_pass();
        int          none_codes[8] = '{0, 6, 7, 11, 12, 13, 14, 15};
        int          mem_codes[8]  = '{1, 2, 3, 4, 5, 8, 9, 10};
        bit          use_mem;
        int          op;
        bit          exp_reg;
        // directed case first, then random ones
        for (int i = 0; i < 25; i++) begin
            use_mem = (i > 0) && ($urandom_range(0, 3) == 0);
            if (i == 0) begin
                op = 0; ex_wdata = 32'h1234; ex_wd = 5'd5; ex_reg = 1'b1; flush = 1'b0;
            end else begin
                op = use_mem ? mem_codes[$urandom_range(0, 7)] : none_codes[$urandom_range(0, 7)];
                ex_wdata = $urandom; ex_wd = 5'($urandom); ex_reg = 1'($urandom);
                flush = use_mem ? 1'b1 : 1'($urandom);
            end
            ex_memop = op[3:0]; ex_maddr = $urandom; ex_sdata = $urandom;
            #1;
            exp_reg = ex_reg && !flush && !ref_is_load(op) && !ref_is_store(op);
            n_cmp++;
            if (mem_wdata !== ex_wdata || mem_wd !== ex_wd || mem_reg !== exp_reg) begin
                n_err++;
                $display("FAIL alu_pass%0d: got %h/%0d/%b want %h/%0d/%b", i, mem_wdata, mem_wd,
                         mem_reg, ex_wdata, ex_wd, exp_reg);
            end
            n_cmp++;
            if (stallreq !== 1'b0 || dbus.req !== 1'b0) begin
                n_err++; $display("FAIL alu_pass%0d stall/req: got %b/%b want 0/0", i, stallreq, dbus.req);
            end
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b0; ex_memop = 4'd0;
    endtask

    task automatic test_directed();
        run_mem(5, 32'h100, 32'h0, $urandom, 5'd3, 1'b1, 3, 32'hDEADBEEF, -1, 1'b0, "lw_ack3");
        run_mem(1, 32'h103, 32'h0, $urandom, 5'd4, 1'b1, 1, 32'h80FFFFFF, -1, 1'b0, "lb");
        run_mem(2, 32'h103, 32'h0, $urandom, 5'd4, 1'b1, 1, 32'h80FFFFFF, -1, 1'b0, "lbu");
        run_mem(4, 32'h102, 32'h0, $urandom, 5'd4, 1'b1, 1, 32'h80FFFFFF, -1, 1'b0, "lhu");
        run_mem(9, 32'h202, 32'h0000ABCD, 32'h55, 5'd6, 1'b1, 1, $urandom, -1, 1'b0, "sh");
        run_mem(5, 32'h40, 32'h0, $urandom, 5'd2, 1'b1, 0, 32'h12345678, -1, 1'b0, "lw_ack_idle");
    endtask

    task automatic test_flush_wait();
        run_mem(5, 32'h300, 32'h0, $urandom, 5'd7, 1'b1, 3, 32'hCAFEF00D, 1, 1'b0, "flush_wait");
        run_mem(5, 32'h304, 32'h0, $urandom, 5'd7, 1'b1, 2, 32'h0BADCAFE, -1, 1'b1, "flush_done");
    endtask

    task automatic test_random_mem();
        int          ops[8] = '{1, 2, 3, 4, 5, 8, 9, 10};
        int          op, ack_at, stall_cycles, flush_at;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            op   = ops[$urandom_range(0, 7)];
            addr = $urandom;
`ifdef MEM_ALIGN_CHK_EN
            if (ref_misaligned(op, addr)) addr = {addr[31:2], 2'b00};
`endif
            ack_at       = $urandom_range(0, 4);
            stall_cycles = (ack_at < 1) ? 2 : ack_at + 1;
            flush_at     = ($urandom_range(0, 3) == 0) ? $urandom_range(1, stall_cycles - 1) : -1;
            run_mem(op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom), ack_at, $urandom,
                    flush_at, ($urandom_range(0, 5) == 0), $sformatf("rnd%0d", i));
        end
    endtask

    task automatic test_reset_wait();
        ex_memop = 4'd5; ex_maddr = 32'h400; ex_wdata = $urandom; ex_wd = 5'd7; ex_reg = 1'b1;
        flush = 1'b0; dbus.ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dbus.req !== 1'b0 || stallreq !== 1'b0 || mem_reg !== 1'b0) begin
            n_err++; $display("FAIL reset_wait: req=%b stall=%b reg=%b want 0", dbus.req, stallreq, mem_reg);
        end
        ex_memop = 4'd0; rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_wdata !== ex_wdata || stallreq !== 1'b0 || mem_reg !== 1'b1) begin
            n_err++;
            $display("FAIL reset_wait idle: got %h/%b/%b want %h/0/1", mem_wdata, stallreq, mem_reg, ex_wdata);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef MEM_ALIGN_CHK_EN
    task automatic test_align();
        ex_memop = 4'd5; ex_maddr = 32'h101; ex_wdata = $urandom; ex_wd = 5'd8; ex_reg = 1'b1;
        flush = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (dbus.req !== 1'b0 || stallreq !== 1'b0 || mem_excp_align !== 1'b1 || mem_reg !== 1'b0) begin
                n_err++;
                $display("FAIL align c%0d: req=%b stall=%b excp=%b reg=%b want 0/0/1/0", c, dbus.req,
                         stallreq, mem_excp_align, mem_reg);
            end
            @(posedge clk);
            @(negedge clk);
        end
        ex_memop = 4'd0;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dbus.ack = 1'b0; dbus.rdata = '0;
        @(negedge clk);
        test_reset();
        test_alu_pass();
        test_directed();
        test_flush_wait();
        test_random_mem();
        test_reset_wait();
`ifdef MEM_ALIGN_CHK_EN
        test_align();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
